// File: rtl/ecap5_dproc_pkg.sv
// Shared definitions for the load/store unit.
//   ls_state_t            : load/store FSM state encoding
//   SEL_BYTE/HALF/WORD    : ls_sel_i size masks (byte/half/word)
//   ls_is_misaligned()    : true when a half or word access is not naturally aligned
package ecap5_dproc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_WAIT_ACK = 2'd2
  } ls_state_t;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  function automatic logic ls_is_misaligned(input logic [3:0] sel, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (sel == SEL_HALF && off[0]) mis = 1'b1;
    if (sel == SEL_WORD && off != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/loadstore_align.sv
// Combinational byte-lane alignment for the load/store unit.
// Load path : shifts the raw bus word down by the byte offset and sign- or
//             zero-extends it according to the size mask.
// Store path: shifts write data and the size mask up into their bus lanes.
// Ports:
//   ld_raw_i/ld_off_i/ld_sel_i/ld_unsigned_i -> ld_data_o
//   st_data_i/st_sel_i/st_off_i             -> st_data_o/st_sel_o
module loadstore_align
  import ecap5_dproc_pkg::*;
(
  input  logic [31:0] ld_raw_i,
  input  logic [1:0]  ld_off_i,
  input  logic [3:0]  ld_sel_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] ld_data_o,
  input  logic [31:0] st_data_i,
  input  logic [3:0]  st_sel_i,
  input  logic [1:0]  st_off_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_sel_o
);

  logic [31:0] ld_shift;

  always_comb begin
    ld_shift = ld_raw_i >> {ld_off_i, 3'b000};
    case (ld_sel_i)
      SEL_BYTE: ld_data_o = {{24{~ld_unsigned_i & ld_shift[7]}}, ld_shift[7:0]};
      SEL_HALF: ld_data_o = {{16{~ld_unsigned_i & ld_shift[15]}}, ld_shift[15:0]};
      default:  ld_data_o = ld_shift;
    endcase
  end

  // Lanes shifted past bit 31 / bit 3 are simply dropped.
  assign st_data_o = st_data_i << {st_off_i, 3'b000};
  assign st_sel_o  = st_sel_i << st_off_i;

endmodule

// File: rtl/loadstore.sv
// Load/store unit: takes one instruction at a time from execute, either
// forwards the ALU result to write-back or performs a single pipelined
// Wishbone B4 access, then presents the result to write-back.
// Ports:
//   clk_i, rst_i (async, active-high)
//   input_valid_i/input_ready_o, result_i, ls_* controls, reg_write_i, reg_addr_i
//   output_valid_o, reg_write_o, reg_addr_o, reg_data_o  (write-back)
//   wb_* (Wishbone master), misaligned_o (only with LOADSTORE_MISALIGN_TRAP_EN)
// Build option: LOADSTORE_MISALIGN_TRAP_EN -- misaligned half/word accesses
// are trapped instead of being issued with truncated lanes.
//
// state       | meaning
// ST_IDLE     | ready for a new instruction, no bus cycle
// ST_REQUEST  | cyc=stb=1, request presented, waiting for !stall
// ST_WAIT_ACK | request accepted, cyc=1, waiting for ack
module loadstore
  import ecap5_dproc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic [31:0] result_i,
  input  logic        ls_enable_i,
  input  logic        ls_write_i,
  input  logic        ls_unsigned_load_i,
  input  logic [3:0]  ls_sel_i,
  input  logic [31:0] ls_write_data_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  output logic        output_valid_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
`ifdef LOADSTORE_MISALIGN_TRAP_EN
  ,
  output logic        misaligned_o
`endif
);

  ls_state_t   state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  lsel_q, lsel_d;
  logic        uns_q, uns_d;
  logic        rw_q, rw_d;
  logic [4:0]  rd_q, rd_d;
  logic        valid_q, valid_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_data_q, reg_data_d;

  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic [3:0]  st_sel;
  logic        trap_w;

  // Load side uses the offset/size captured at accept; store side works on
  // the live inputs so the lanes are ready when the request is registered.
  loadstore_align u_align (
    .ld_raw_i      (wb_dat_i),
    .ld_off_i      (off_q),
    .ld_sel_i      (lsel_q),
    .ld_unsigned_i (uns_q),
    .ld_data_o     (ld_data),
    .st_data_i     (ls_write_data_i),
    .st_sel_i      (ls_sel_i),
    .st_off_i      (result_i[1:0]),
    .st_data_o     (st_data),
    .st_sel_o      (st_sel)
  );

`ifdef LOADSTORE_MISALIGN_TRAP_EN
  assign trap_w = ls_is_misaligned(ls_sel_i, result_i[1:0]);
`else
  assign trap_w = 1'b0;
`endif

  always_comb begin
    logic complete;
    complete    = 1'b0;
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    off_d       = off_q;
    lsel_d      = lsel_q;
    uns_d       = uns_q;
    rw_d        = rw_q;
    rd_d        = rd_q;
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;

    case (state_q)
      ST_IDLE: begin
        if (input_valid_i) begin
          if (!ls_enable_i) begin
            valid_d     = 1'b1;
            reg_write_d = reg_write_i;
            reg_addr_d  = reg_addr_i;
            reg_data_d  = result_i;
          end else if (trap_w) begin
            valid_d    = 1'b1;
            reg_addr_d = reg_addr_i;
            reg_data_d = '0;
          end else begin
            state_d = ST_REQUEST;
            adr_d   = {result_i[31:2], 2'b00};
            dat_d   = st_data;
            sel_d   = st_sel;
            we_d    = ls_write_i;
            off_d   = result_i[1:0];
            lsel_d  = ls_sel_i;
            uns_d   = ls_unsigned_load_i;
            rw_d    = reg_write_i;
            rd_d    = reg_addr_i;
          end
        end
      end
      ST_REQUEST: begin
        // An ack is only meaningful once the request has been accepted.
        if (!wb_stall_i) begin
          if (wb_ack_i) complete = 1'b1;
          else          state_d  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (wb_ack_i) complete = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      state_d     = ST_IDLE;
      we_d        = 1'b0;
      valid_d     = 1'b1;
      reg_write_d = rw_q;
      reg_addr_d  = rd_q;
      reg_data_d  = we_q ? 32'h0 : ld_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      lsel_q      <= '0;
      uns_q       <= 1'b0;
      rw_q        <= 1'b0;
      rd_q        <= '0;
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      off_q       <= off_d;
      lsel_q      <= lsel_d;
      uns_q       <= uns_d;
      rw_q        <= rw_d;
      rd_q        <= rd_d;
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
    end
  end

`ifdef LOADSTORE_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mis_q <= 1'b0;
    else       mis_q <= (state_q == ST_IDLE) && input_valid_i && ls_enable_i && trap_w;
  end
  assign misaligned_o = mis_q;
`endif

  // cyc/stb decode straight from state so a reset drops them immediately.
  assign input_ready_o  = (state_q == ST_IDLE);
  assign wb_cyc_o       = (state_q != ST_IDLE);
  assign wb_stb_o       = (state_q == ST_REQUEST);
  assign wb_adr_o       = adr_q;
  assign wb_dat_o       = dat_q;
  assign wb_sel_o       = sel_q;
  assign wb_we_o        = we_q;
  assign output_valid_o = valid_q;
  assign reg_write_o    = reg_write_q;
  assign reg_addr_o     = reg_addr_q;
  assign reg_data_o     = reg_data_q;

endmodule

// File: tb/tb_loadstore.sv
module tb_loadstore;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        input_valid_i = 1'b0;
  logic        input_ready_o;
  logic [31:0] result_i = '0;
  logic        ls_enable_i = 1'b0;
  logic        ls_write_i = 1'b0;
  logic        ls_unsigned_load_i = 1'b0;
  logic [3:0]  ls_sel_i = '0;
  logic [31:0] ls_write_data_i = '0;
  logic        reg_write_i = 1'b0;
  logic [4:0]  reg_addr_i = '0;
  logic        output_valid_o;
  logic        reg_write_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_stall_i = 1'b0;
`ifdef LOADSTORE_MISALIGN_TRAP_EN
  logic        misaligned_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  loadstore dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
    .result_i(result_i), .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i),
    .ls_unsigned_load_i(ls_unsigned_load_i), .ls_sel_i(ls_sel_i),
    .ls_write_data_i(ls_write_data_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .output_valid_o(output_valid_o), .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
`ifdef LOADSTORE_MISALIGN_TRAP_EN
    , .misaligned_o(misaligned_o)
`endif
  );

  typedef struct {
    logic [31:0] adr, dat, reg_data;
    logic [3:0]  sel;
    logic [4:0]  reg_addr;
    logic        we, reg_write, stable, timeout, cyc_at_valid;
    int          stb_cycles, ready_hi, wait_bad, lat, valids;
  } acc_res_t;

  // Reference model: size in bytes (1/2/4), offset in bytes.
  function automatic logic [31:0] model_load(input logic [31:0] d, input int off, input int size, input bit uns);
    longint v;
    longint span;
    v = longint'(d) / (longint'(1) << (8 * off));
    if (size == 4) return v[31:0];
    span = longint'(1) << (8 * size);
    v = v % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_sel(input int size, input int off);
    int m;
    m = (((1 << size) - 1) * (1 << off)) % 16;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_sdat(input logic [31:0] w, input int off);
    longint v;
    v = (longint'(w) * (longint'(1) << (8 * off))) % (longint'(1) << 32);
    return v[31:0];
  endfunction

  function automatic logic [3:0] size_to_sel(input int size);
    logic [3:0] s;
    s = (size == 1) ? 4'b0001 : (size == 2) ? 4'b0011 : 4'b1111;
    return s;
  endfunction

  // Drives one LS access from the current negedge and plays the bus slave;
  // stall_n stalled cycles, ack arriving ack_d cycles after request acceptance.
  task automatic bus_access(input logic [31:0] addr, input bit we, input logic [3:0] sel,
                            input bit uns, input logic [31:0] wdata, input logic [31:0] rdata,
                            input int stall_n, input int ack_d, input logic [4:0] rd,
                            input bit rw, output acc_res_t r);
    int stalls;
    int guard;
    bit acked;
    r.adr = '0; r.dat = '0; r.reg_data = '0; r.sel = '0; r.reg_addr = '0;
    r.we = 0; r.reg_write = 0; r.stable = 1; r.timeout = 0; r.cyc_at_valid = 0;
    r.stb_cycles = 0; r.ready_hi = 0; r.wait_bad = 0; r.lat = 0; r.valids = 0;
    input_valid_i = 1; result_i = addr; ls_enable_i = 1; ls_write_i = we;
    ls_unsigned_load_i = uns; ls_sel_i = sel; ls_write_data_i = wdata;
    reg_write_i = rw; reg_addr_i = rd;
    @(negedge clk_i); r.lat = 1;
    input_valid_i = 0; ls_enable_i = 0; ls_write_data_i = $urandom;
    r.adr = wb_adr_o; r.sel = wb_sel_o; r.dat = wb_dat_o; r.we = wb_we_o;
    stalls = stall_n; acked = 0; guard = 0;
    while (wb_stb_o && guard < 40) begin
      r.stb_cycles++;
      if (wb_adr_o !== r.adr || wb_sel_o !== r.sel || wb_dat_o !== r.dat ||
          wb_we_o !== r.we || !wb_cyc_o) r.stable = 0;
      if (input_ready_o) r.ready_hi++;
      if (stalls > 0) begin
        wb_stall_i = 1; wb_ack_i = 0; stalls--;
      end else begin
        wb_stall_i = 0; acked = (ack_d == 0); wb_ack_i = acked;
        wb_dat_i = acked ? rdata : $urandom;
      end
      @(negedge clk_i); r.lat++; guard++;
    end
    wb_stall_i = 0; wb_ack_i = 0;
    if (guard >= 40 || r.stb_cycles == 0) r.timeout = 1;
    if (!acked && !r.timeout) begin
      for (int k = 1; k <= ack_d; k++) begin
        if (!wb_cyc_o || wb_stb_o) r.wait_bad++;
        if (input_ready_o) r.ready_hi++;
        wb_ack_i = (k == ack_d);
        wb_dat_i = (k == ack_d) ? rdata : $urandom;
        @(negedge clk_i); r.lat++;
      end
    end
    wb_ack_i = 0; wb_dat_i = $urandom;
    guard = 0;
    while (!output_valid_o && guard < 10) begin
      @(negedge clk_i); r.lat++; guard++;
    end
    if (!output_valid_o) r.timeout = 1;
    else r.valids = 1;
    r.reg_data = reg_data_o; r.reg_write = reg_write_o; r.reg_addr = reg_addr_o;
    r.cyc_at_valid = wb_cyc_o;
    repeat (3) begin
      @(negedge clk_i);
      if (output_valid_o) r.valids++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i); rst_i = 1;
    @(negedge clk_i);
    checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_cyc got=%0b exp=0", wb_cyc_o); end
    checks++; if (wb_stb_o !== 1'b0) begin failures++; $display("FAIL reset_stb got=%0b exp=0", wb_stb_o); end
    checks++; if (wb_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", wb_we_o); end
    checks++; if (output_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", output_valid_o); end
    checks++; if (reg_write_o !== 1'b0) begin failures++; $display("FAIL reset_reg_write got=%0b exp=0", reg_write_o); end
    checks++; if (input_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", input_ready_o); end
    checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin failures++; $display("FAIL reset_bus adr=%h dat=%h sel=%b exp=0", wb_adr_o, wb_dat_o, wb_sel_o); end
    checks++; if ({reg_addr_o, reg_data_o} !== 37'h0) begin failures++; $display("FAIL reset_wb addr=%0d data=%h exp=0", reg_addr_o, reg_data_o); end
`ifdef LOADSTORE_MISALIGN_TRAP_EN
    checks++; if (misaligned_o !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%0b exp=0", misaligned_o); end
`endif
    rst_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_passthrough();
    logic [31:0] res;
    logic [4:0]  ra;
    logic        rw;
    for (int i = 0; i < 6; i++) begin
      res = (i == 0) ? 32'h1234 : $urandom;
      ra  = (i == 0) ? 5'd5 : 5'($urandom);
      rw  = (i == 0) ? 1'b1 : 1'($urandom);
      input_valid_i = 1; ls_enable_i = 0; result_i = res; reg_addr_i = ra; reg_write_i = rw;
      @(negedge clk_i);
      input_valid_i = 0;
      checks++; if (output_valid_o !== 1'b1) begin failures++; $display("FAIL pass_valid[%0d] got=%0b exp=1", i, output_valid_o); end
      checks++; if (reg_data_o !== res) begin failures++; $display("FAIL pass_data[%0d] got=%h exp=%h", i, reg_data_o, res); end
      checks++; if (reg_addr_o !== ra || reg_write_o !== rw) begin failures++; $display("FAIL pass_addr[%0d] got=%0d/%0b exp=%0d/%0b", i, reg_addr_o, reg_write_o, ra, rw); end
      checks++; if (wb_cyc_o !== 1'b0 || input_ready_o !== 1'b1) begin failures++; $display("FAIL pass_idle[%0d] cyc=%0b ready=%0b exp=0/1", i, wb_cyc_o, input_ready_o); end
      @(negedge clk_i);
      checks++; if (output_valid_o !== 1'b0) begin failures++; $display("FAIL pass_pulse[%0d] got=%0b exp=0", i, output_valid_o); end
    end
  endtask

  task automatic test_lb();
    acc_res_t r;
    bus_access(32'h103, 0, 4'b0001, 0, 32'h0, 32'h80FF_FF00, 0, 0, 5'd7, 1, r);
    checks++; if (r.sel !== 4'b1000 || r.adr !== 32'h100 || r.we !== 1'b0) begin failures++; $display("FAIL lb_req sel=%b adr=%h we=%0b exp=1000/100/0", r.sel, r.adr, r.we); end
    checks++; if (r.reg_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", r.reg_data); end
    checks++; if (r.lat !== 2 || r.timeout) begin failures++; $display("FAIL lb_latency got=%0d to=%0b exp=2", r.lat, r.timeout); end
    checks++; if (r.reg_write !== 1'b1 || r.reg_addr !== 5'd7) begin failures++; $display("FAIL lb_wb got=%0b/%0d exp=1/7", r.reg_write, r.reg_addr); end
    bus_access(32'h103, 0, 4'b0001, 1, 32'h0, 32'h80FF_FF00, 0, 0, 5'd8, 1, r);
    checks++; if (r.reg_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", r.reg_data); end
    checks++; if (r.valids !== 1) begin failures++; $display("FAIL lbu_pulses got=%0d exp=1", r.valids); end
  endtask

  task automatic test_sh_stall();
    acc_res_t r;
    bus_access(32'h202, 1, 4'b0011, 0, 32'h0000_ABCD, 32'h5555_5555, 3, 0, 5'd3, 0, r);
    checks++; if (r.adr !== 32'h200 || r.sel !== 4'b1100 || r.dat !== 32'hABCD_0000 || r.we !== 1'b1) begin failures++; $display("FAIL sh_req adr=%h sel=%b dat=%h we=%0b exp=200/1100/abcd0000/1", r.adr, r.sel, r.dat, r.we); end
    checks++; if (r.stb_cycles !== 4 || r.stable !== 1'b1) begin failures++; $display("FAIL sh_stall stb_cycles=%0d stable=%0b exp=4/1", r.stb_cycles, r.stable); end
    checks++; if (r.reg_data !== 32'h0 || r.reg_write !== 1'b0) begin failures++; $display("FAIL sh_wb data=%h wr=%0b exp=0/0", r.reg_data, r.reg_write); end
    checks++; if (r.lat !== 5 || r.timeout) begin failures++; $display("FAIL sh_latency got=%0d to=%0b exp=5", r.lat, r.timeout); end
  endtask

  task automatic test_ack_delay();
    acc_res_t r;
    bus_access(32'h300, 0, 4'b1111, 0, 32'h0, 32'hCAFE_F00D, 0, 5, 5'd9, 1, r);
    checks++; if (r.ready_hi !== 0) begin failures++; $display("FAIL delay_ready high_cycles=%0d exp=0", r.ready_hi); end
    checks++; if (r.wait_bad !== 0) begin failures++; $display("FAIL delay_wait bad_cycles=%0d exp=0", r.wait_bad); end
    checks++; if (r.valids !== 1 || r.timeout) begin failures++; $display("FAIL delay_pulses got=%0d to=%0b exp=1", r.valids, r.timeout); end
    checks++; if (r.reg_data !== 32'hCAFE_F00D || r.cyc_at_valid !== 1'b0) begin failures++; $display("FAIL delay_data got=%h cyc=%0b exp=cafef00d/0", r.reg_data, r.cyc_at_valid); end
    checks++; if (r.lat !== 7) begin failures++; $display("FAIL delay_latency got=%0d exp=7", r.lat); end
  endtask

  task automatic test_idle_ack();
    int bad;
    bad = 0;
    wb_ack_i = 1; wb_dat_i = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk_i);
      if (output_valid_o || wb_cyc_o || !input_ready_o) bad++;
    end
    wb_ack_i = 0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL idle_ack bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    acc_res_t r;
    int vcount;
    input_valid_i = 1; ls_enable_i = 1; ls_write_i = 0; ls_sel_i = 4'b1111;
    result_i = 32'h40; reg_addr_i = 5'd4; reg_write_i = 1;
    @(negedge clk_i);
    input_valid_i = 0; ls_enable_i = 0;
    wb_stall_i = 0; wb_ack_i = 0;
    @(negedge clk_i);
    checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin failures++; $display("FAIL rstmid_wait cyc=%0b stb=%0b exp=1/0", wb_cyc_o, wb_stb_o); end
    #2 rst_i = 1; wb_ack_i = 1; wb_dat_i = 32'h1111_2222;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin failures++; $display("FAIL rstmid_drop cyc=%0b stb=%0b exp=0/0", wb_cyc_o, wb_stb_o); end
    @(negedge clk_i);
    rst_i = 0;
    vcount = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (output_valid_o) vcount++;
      wb_ack_i = 0;
    end
    checks++; if (vcount !== 0) begin failures++; $display("FAIL rstmid_novalid pulses=%0d exp=0", vcount); end
    bus_access(32'h44, 0, 4'b1111, 0, 32'h0, 32'h7654_3210, 1, 1, 5'd11, 1, r);
    checks++; if (r.reg_data !== 32'h7654_3210 || r.adr !== 32'h44 || r.valids !== 1 || r.timeout) begin failures++; $display("FAIL rstmid_next data=%h adr=%h pulses=%0d exp=76543210/44/1", r.reg_data, r.adr, r.valids); end
  endtask

`ifdef LOADSTORE_MISALIGN_TRAP_EN
  task automatic test_misalign();
    int cyc_seen;
    input_valid_i = 1; ls_enable_i = 1; ls_write_i = 0; ls_sel_i = 4'b1111;
    result_i = 32'h102; reg_addr_i = 5'd6; reg_write_i = 1;
    @(negedge clk_i);
    input_valid_i = 0; ls_enable_i = 0;
    cyc_seen = wb_cyc_o;
    checks++; if (output_valid_o !== 1'b1 || misaligned_o !== 1'b1 || reg_write_o !== 1'b0) begin failures++; $display("FAIL trap_pulse valid=%0b mis=%0b wr=%0b exp=1/1/0", output_valid_o, misaligned_o, reg_write_o); end
    @(negedge clk_i);
    if (wb_cyc_o) cyc_seen++;
    checks++; if (cyc_seen !== 0) begin failures++; $display("FAIL trap_nocyc cyc_cycles=%0d exp=0", cyc_seen); end
    checks++; if (misaligned_o !== 1'b0 || output_valid_o !== 1'b0) begin failures++; $display("FAIL trap_once mis=%0b valid=%0b exp=0/0", misaligned_o, output_valid_o); end
  endtask
`else
  task automatic test_truncate();
    acc_res_t r;
    bus_access(32'h102, 1, 4'b1111, 0, 32'h1122_3344, 32'h0, 0, 0, 5'd2, 0, r);
    checks++; if (r.adr !== 32'h100 || r.sel !== 4'b1100 || r.dat !== 32'h3344_0000) begin failures++; $display("FAIL trunc_req adr=%h sel=%b dat=%h exp=100/1100/33440000", r.adr, r.sel, r.dat); end
    checks++; if (r.valids !== 1 || r.timeout) begin failures++; $display("FAIL trunc_done pulses=%0d to=%0b exp=1", r.valids, r.timeout); end
  endtask
`endif

  task automatic test_random();
    acc_res_t r;
    int size, off, st, ad;
    bit we, uns, rw;
    logic [31:0] base, addr, wdata, rdata;
    logic [4:0] rd;
    for (int i = 0; i < 25; i++) begin
      size = 1 << $urandom_range(0, 2);
      off = $urandom_range(0, 3);
`ifdef LOADSTORE_MISALIGN_TRAP_EN
      off = off - (off % size);
`endif
      base = $urandom; addr = {base[31:2], 2'b00} + 32'(off);
      we = 1'($urandom); uns = 1'($urandom); rw = we ? 1'b0 : 1'($urandom);
      wdata = $urandom; rdata = $urandom; rd = 5'($urandom);
      st = $urandom_range(0, 2); ad = $urandom_range(0, 3);
      bus_access(addr, we, size_to_sel(size), uns, wdata, rdata, st, ad, rd, rw, r);
      checks++; if (r.adr !== {addr[31:2], 2'b00} || r.sel !== model_sel(size, off) || r.we !== we) begin failures++; $display("FAIL rnd_req[%0d] adr=%h sel=%b we=%0b exp=%h/%b/%0b", i, r.adr, r.sel, r.we, {addr[31:2], 2'b00}, model_sel(size, off), we); end
      if (we) begin
        checks++; if (r.dat !== model_sdat(wdata, off)) begin failures++; $display("FAIL rnd_sdat[%0d] got=%h exp=%h", i, r.dat, model_sdat(wdata, off)); end
      end
      checks++; if (r.reg_data !== (we ? 32'h0 : model_load(rdata, off, size, uns))) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, r.reg_data, we ? 32'h0 : model_load(rdata, off, size, uns)); end
      checks++; if (r.reg_write !== rw || r.reg_addr !== rd) begin failures++; $display("FAIL rnd_wb[%0d] got=%0b/%0d exp=%0b/%0d", i, r.reg_write, r.reg_addr, rw, rd); end
      checks++; if (r.lat !== 2 + st + ad || r.valids !== 1 || r.stable !== 1'b1 || r.timeout) begin failures++; $display("FAIL rnd_timing[%0d] lat=%0d pulses=%0d stable=%0b exp=%0d/1/1", i, r.lat, r.valids, r.stable, 2 + st + ad); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_lb();
    test_sh_stall();
    test_ack_delay();
    test_idle_ack();
    test_reset_mid();
`ifdef LOADSTORE_MISALIGN_TRAP_EN
    test_misalign();
`else
    test_truncate();
`endif
    test_random();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loadstore.md
LOADSTORE -- requirements
Module: loadstore

Interface
REQ-001 SHALL have macro LOADSTORE_MISALIGN_TRAP_EN, default undefined, meaning misaligned accesses are trapped instead of issued.
REQ-002 SHALL have ports clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-003 SHALL have input_valid_i in 1 and input_ready_o out 1: upstream handshake from execute.
REQ-004 SHALL have result_i in 32: ALU result, used as address or as write-back data.
REQ-005 SHALL have ls_enable_i, ls_write_i, ls_unsigned_load_i in 1 each, plus ls_sel_i in 4: size mask 0001/0011/1111 = byte/half/word.
REQ-006 SHALL have ls_write_data_i in 32, reg_write_i in 1 and reg_addr_i in 5.
REQ-007 SHALL have output_valid_o out 1, reg_write_o out 1, reg_addr_o out 5 and reg_data_o out 32: write-back stage.
REQ-008 SHALL have wb_adr_o out 32, wb_dat_o out 32, wb_sel_o out 4, wb_we_o/wb_stb_o/wb_cyc_o out 1 each: pipelined Wishbone B4 master.
REQ-009 SHALL have wb_dat_i in 32 and wb_ack_i/wb_stall_i in 1 each.
REQ-010 SHALL have misaligned_o out 1: trap pulse; present only with the macro.

Function
REQ-011 SHALL implement FSM states IDLE, REQUEST, WAIT_ACK; input_ready_o = (state==IDLE).
REQ-012 SHALL accept a transfer on input_valid_i && input_ready_o.
REQ-013 SHALL, on an accept with ls_enable_i=0, drive output_valid_o=1 the next cycle for one cycle, with reg_data_o=result_i and reg_write_o/reg_addr_o passed through; the FSM stays in IDLE.
REQ-014 SHALL, on an accept with ls_enable_i=1, enter REQUEST the next cycle with cyc=stb=1, wb_adr_o={result_i[31:2],2'b00}, wb_we_o=ls_write_i.
REQ-015 SHALL drive wb_sel_o = ls_sel_i << result_i[1:0] and wb_dat_o = ls_write_data_i << 8*result_i[1:0].
REQ-016 SHALL hold REQUEST and all wb outputs stable while wb_stall_i=1; on stb && !stall it enters WAIT_ACK with stb=0, cyc=1.
REQ-017 SHALL treat wb_ack_i in REQUEST with stall=0 as completion, returning to IDLE directly.
REQ-018 SHALL, on completion, drop cyc, return to IDLE and pulse output_valid_o the next cycle.
REQ-019 SHALL set load data to wb_dat_i >> 8*addr[1:0], sign-extended from bit 7/15 per ls_sel, or zero-extended if ls_unsigned_load_i; a word load is unextended.
REQ-020 SHALL give a store reg_write_o = reg_write_i (0 from decode) and reg_data_o = 0.
REQ-021 SHALL ignore wb_ack_i in IDLE.
REQ-022 SHALL have a minimum memory latency of 2 cycles from accept to output_valid_o; an access is never issued back-to-back, at most one outstanding.

Reset
REQ-023 SHALL asynchronously force state=IDLE and set cyc, stb, we, output_valid_o, reg_write_o and misaligned_o to 0, with wb_adr_o, wb_dat_o, wb_sel_o, reg_addr_o and reg_data_o set to 0.
REQ-024 SHALL, on reset mid-transfer, drop cyc/stb immediately, discard the transfer, and emit no output_valid_o.

Configuration
REQ-025 SHALL, with LOADSTORE_MISALIGN_TRAP_EN defined, treat a half access with addr[0]=1 or a word access with addr[1:0]!=0 as misaligned: it is not issued and the next cycle gives output_valid_o=1, reg_write_o=0, misaligned_o=1 for one cycle.
REQ-026 SHALL, without the macro, issue such an access with wb_sel_o truncated to 4 bits (upper lanes dropped); misaligned_o is absent.

Structure
REQ-027 SHALL place the FSM state enum and the size-mask constants SEL_BYTE/SEL_HALF/SEL_WORD in ecap5_dproc_pkg.
REQ-028 SHALL have one sub-module, loadstore_align: a combinational lane shift and extend for the load path, reused for store data/sel.

Verification
REQ-029 SHALL verify: non-LS accept with result_i=0x1234 and reg_addr 5 -> next cycle output_valid_o=1, reg_data_o=0x1234, reg_addr_o=5.
REQ-030 SHALL verify: LB at 0x103 with wb_dat_i=0x80FF_FF00 and ack at first stb -> wb_sel_o=1000, reg_data_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-031 SHALL verify: SH at 0x202 with data 0xABCD and stall held 3 cycles -> adr 0x200, sel 1100, dat 0xABCD0000 stable for 4 cycles, then stb=0.
REQ-032 SHALL verify: ack delayed 5 cycles in WAIT_ACK -> input_ready_o=0 throughout, one output_valid_o pulse after ack.
REQ-033 SHALL verify: rst_i asserted in WAIT_ACK -> cyc=0 in the same cycle, no output_valid_o, and a new accept works.
REQ-034 SHALL verify, with the macro: LW at 0x102 -> no cyc, misaligned_o=1 and reg_write_o=0 for one cycle.
